// File: rtl/threshold_compare_pkg.sv
// rtl/threshold_compare_pkg.sv - shared encodings for threshold_compare_seq
//
// Contents:
//   MODE_LT/LE/GT/EQ : 2-bit compare mode encodings (sample op threshold)
//   IDLE/RUN/TRIP    : run detector FSM state encodings
package threshold_compare_pkg;

  // Compare modes, applied as "sample <op> threshold".
  localparam logic [1:0] MODE_LT = 2'b00;
  localparam logic [1:0] MODE_LE = 2'b01;
  localparam logic [1:0] MODE_GT = 2'b10;
  localparam logic [1:0] MODE_EQ = 2'b11;

  // Run detector states.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] TRIP = 2'b10;

endpackage

// File: rtl/threshold_compare_seq_if.sv
// rtl/threshold_compare_seq_if.sv - sample/config/result bundle for threshold_compare_seq
//
// Signals:
//   in_valid, in_data, mode       : sample stream and its compare mode
//   cfg_load, cfg_thresh          : threshold load request
//   clr                           : synchronous clear of run state and hit counter
//   y, y_valid                    : registered compare result
//   run_flag, hit_cnt, thresh_q   : run status, hit count, current threshold
// Modports:
//   master : sample source / configuration side
//   slave  : comparator side
interface threshold_compare_seq_if #(
  parameter int WIDTH = 3,
  parameter int HIT_W = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             cfg_load;
  logic [WIDTH-1:0] cfg_thresh;
  logic             clr;
  logic             y;
  logic             y_valid;
  logic             run_flag;
  logic [HIT_W-1:0] hit_cnt;
  logic [WIDTH-1:0] thresh_q;

  modport master (
    output in_valid, in_data, mode, cfg_load, cfg_thresh, clr,
    input  y, y_valid, run_flag, hit_cnt, thresh_q
  );

  modport slave (
    input  in_valid, in_data, mode, cfg_load, cfg_thresh, clr,
    output y, y_valid, run_flag, hit_cnt, thresh_q
  );

endinterface

// File: rtl/threshold_compare_seq_run_detector.sv
// rtl/threshold_compare_seq_run_detector.sv - consecutive-true run detector
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over hit_valid
//   hit_valid  : hit qualifies this cycle (an accepted sample)
//   hit        : compare result of the accepted sample
//   run_flag   : registered, high while RUN_LEN or more consecutive hits
module run_detector
  import threshold_compare_pkg::*;
#(
  parameter int RUN_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hit_valid,
  input  logic hit,
  output logic run_flag
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  // Idle cycles (hit_valid low) hold state, so they neither extend nor
  // break a run. Once in TRIP the counter sits at RUN_LEN.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (hit_valid) begin
      case (state)
        IDLE: begin
          if (hit) begin
            cnt_d   = CNT_ONE;
            state_d = (RUN_LEN == 1) ? TRIP : RUN;
          end
        end
        RUN: begin
          if (hit) begin
            cnt_d = cnt + CNT_ONE;
            if (cnt_d == CNT_MAX) begin
              state_d = TRIP;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        TRIP: begin
          if (!hit) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // run_flag is registered from the next state so it lines up with the
  // y_valid cycle that shows the triggering (or breaking) result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      run_flag <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      run_flag <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      run_flag <= (state_d == TRIP);
    end
  end

endmodule

// File: rtl/threshold_compare_seq.sv
// rtl/threshold_compare_seq.sv - registered threshold comparator with run and hit tracking
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : threshold_compare_seq_if.slave
//           in_valid/in_data/mode  sample and compare mode (sampled together)
//           cfg_load/cfg_thresh    threshold load; same-edge sample uses old value
//           clr                    clears run state and hit counter, drops the sample
//           y/y_valid              compare result, one cycle after acceptance
//           run_flag               RUN_LEN or more consecutive true results
//           hit_cnt                saturating count of true results
//           thresh_q               current threshold
module threshold_compare_seq
  import threshold_compare_pkg::*;
#(
  parameter int WIDTH          = 3,
  parameter int THRESH_DEFAULT = 3,
  parameter int RUN_LEN        = 4,
  parameter int HIT_W          = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  threshold_compare_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] THRESH_RST = WIDTH'(THRESH_DEFAULT);
  localparam logic [HIT_W-1:0] HIT_MAX    = {HIT_W{1'b1}};
  localparam logic [HIT_W-1:0] HIT_ONE    = HIT_W'(1);

  logic [WIDTH-1:0] thresh_r;
  logic             y_r;
  logic             y_valid_r;
  logic [HIT_W-1:0] hit_r;
  logic             cmp;
  logic             accept;
  logic             run_flag_w;

  // clr discards any sample presented in the same cycle.
  assign accept = bus.in_valid && !bus.clr;

  // Unsigned compare against the threshold currently held, so a cfg_load
  // on the same edge never affects this sample.
  always_comb begin
    cmp = 1'b0;
    case (bus.mode)
      MODE_LT: cmp = (bus.in_data <  thresh_r);
      MODE_LE: cmp = (bus.in_data <= thresh_r);
      MODE_GT: cmp = (bus.in_data >  thresh_r);
      MODE_EQ: cmp = (bus.in_data == thresh_r);
      default: cmp = 1'b0;
    endcase
  end

  // Threshold is configuration state: clr leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_r <= THRESH_RST;
    end else if (bus.cfg_load) begin
      thresh_r <= bus.cfg_thresh;
    end
  end

  // y holds its last value through idle and clear cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= 1'b0;
      y_valid_r <= 1'b0;
    end else begin
      y_valid_r <= accept;
      if (accept) begin
        y_r <= cmp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r <= '0;
    end else if (bus.clr) begin
      hit_r <= '0;
    end else if (accept && cmp && (hit_r != HIT_MAX)) begin
      hit_r <= hit_r + HIT_ONE;
    end
  end

  run_detector #(
    .RUN_LEN (RUN_LEN)
  ) u_run_detector (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .hit_valid (bus.in_valid),
    .hit       (cmp),
    .run_flag  (run_flag_w)
  );

  assign bus.y        = y_r;
  assign bus.y_valid  = y_valid_r;
  assign bus.run_flag = run_flag_w;
  assign bus.hit_cnt  = hit_r;
  assign bus.thresh_q = thresh_r;

endmodule
